intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter T_GREEN, default 60, full green duration in cycles (1..255).
REQ-002 SHALL have parameter T_SHORT, default 10, green remaining after a cross-request shortening (1..T_GREEN).
REQ-003 SHALL have parameter T_YELLOW, default 5, yellow duration in cycles (1..255).
REQ-004 SHALL have parameter T_ALLRED, default 2, all-red clearance duration in cycles (1..255).
REQ-005 SHALL have parameter T_FLASH, default 4, flash half-period in cycles (1..255).
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port ns_req  input  1  north-south crossing request, one-cycle pulse or level.
REQ-009 SHALL have port ew_req  input  1  east-west crossing request, one-cycle pulse or level.
REQ-010 SHALL have port flash  input  1  level; selects flashing-yellow fault mode.
REQ-011 SHALL have ports ns_red, ns_yellow, ns_green  output  1 each  NS lamp drives, registered.
REQ-012 SHALL have ports ew_red, ew_yellow, ew_green  output  1 each  EW lamp drives, registered.
REQ-013 SHALL have port phase  output  3  current state code.
REQ-014 SHALL have port timer  output  8  remaining cycles in current state, including current cycle.

Function
REQ-015 SHALL implement states (phase code): INIT_RED=0, NS_GREEN=1, NS_YELLOW=2, ALL_RED1=3, EW_GREEN=4, EW_YELLOW=5, ALL_RED2=6, FLASH=7.
REQ-016 SHALL sequence INIT_RED->NS_GREEN->NS_YELLOW->ALL_RED1->EW_GREEN->EW_YELLOW->ALL_RED2->NS_GREEN, repeating.
REQ-017 SHALL load timer on state entry with that state's duration (GREEN: T_GREEN, YELLOW: T_YELLOW, INIT_RED/ALL_RED: T_ALLRED), decrement by 1 each other cycle, and transition on the edge where timer==1; each state thus lasts exactly its duration.
REQ-018 SHALL drive lamps from the state register: exactly one lamp per direction on; the direction not in GREEN/YELLOW shows red; INIT_RED and ALL_RED* show red on both.
REQ-019 SHALL never drive green or yellow on both directions simultaneously outside FLASH.
REQ-020 SHALL latch ew_pend when ew_req=1 and state!=EW_GREEN; clear ew_pend on the edge entering EW_GREEN (clear wins over simultaneous ew_req). ns_pend symmetric for NS.
REQ-021 SHALL ignore ns_req while in NS_GREEN and ew_req while in EW_GREEN.
REQ-022 SHALL, in NS_GREEN, on any edge where (ew_req|ew_pend)=1 and timer>T_SHORT, load timer with T_SHORT instead of decrementing; if timer<=T_SHORT, decrement normally. EW_GREEN symmetric with ns_req/ns_pend.
REQ-023 SHALL, when flash=1, enter FLASH at the next edge from any state, with timer=T_FLASH and all lamps off.
REQ-024 SHALL, in FLASH, hold all red/green off and toggle both yellows together every T_FLASH cycles (timer reload at 1), first toggle turning them on.
REQ-025 SHALL, when flash=0 in FLASH, enter INIT_RED at the next edge with timer=T_ALLRED; pending flags retained across FLASH.
REQ-026 SHALL treat flash as highest priority over timer expiry and shortening on the same edge.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force state=INIT_RED, timer=T_ALLRED, ns_red=ew_red=1, all other lamps 0, ns_pend=ew_pend=0.
REQ-028 SHALL, after rst_n deasserts, begin counting at the first clk edge; reset mid-sequence returns to INIT_RED immediately regardless of state.

Verification
REQ-029 SHALL cover: release reset, no requests -> INIT_RED 2 cycles, NS_GREEN 60, NS_YELLOW 5, ALL_RED1 2, EW_GREEN 60, EW_YELLOW 5, ALL_RED2 2, NS_GREEN again (period 134).
REQ-030 SHALL cover: ew_req pulse while NS_GREEN timer=40 -> next edge timer=10, NS_GREEN ends 10 cycles later, EW_GREEN entered 7 cycles after that with ew_pend=0.
REQ-031 SHALL cover: ew_req pulse while NS_GREEN timer=6 -> no reload, timer continues 5,4,...; ew_pend cleared on EW_GREEN entry.
REQ-032 SHALL cover: ew_req during NS_YELLOW -> ew_pend=1 until EW_GREEN entry; ns_req during NS_GREEN -> no effect, ns_pend stays 0.
REQ-033 SHALL cover: flash=1 during EW_GREEN -> next edge phase=7, lamps off; yellows on 4 cycles, off 4 cycles; flash=0 -> INIT_RED, timer=2, both red.
REQ-034 SHALL cover: rst_n pulled low mid-EW_YELLOW without clock -> immediately both red, phase=0, timer=2; every cycle, assertion that no two directions show non-red outside FLASH.

Source files
------------

// File: rtl/intersection_ctrl.sv
// Two-way traffic intersection controller: fixed green/yellow/all-red cycle with
// cross-request green shortening and a flashing-yellow fault mode.
module intersection_ctrl #(
  parameter int unsigned T_GREEN  = 60,
  parameter int unsigned T_SHORT  = 10,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_FLASH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       flash,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase,
  output logic [7:0] timer
);

  typedef enum logic [2:0] {
    StInitRed  = 3'd0,
    StNsGreen  = 3'd1,
    StNsYellow = 3'd2,
    StAllRed1  = 3'd3,
    StEwGreen  = 3'd4,
    StEwYellow = 3'd5,
    StAllRed2  = 3'd6,
    StFlash    = 3'd7
  } state_e;

  localparam logic [7:0] TGreen  = 8'(T_GREEN);
  localparam logic [7:0] TShort  = 8'(T_SHORT);
  localparam logic [7:0] TYellow = 8'(T_YELLOW);
  localparam logic [7:0] TAllRed = 8'(T_ALLRED);
  localparam logic [7:0] TFlash  = 8'(T_FLASH);

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] LampRedRed    = 6'b100_100;
  localparam logic [5:0] LampNsGreen   = 6'b001_100;
  localparam logic [5:0] LampNsYellow  = 6'b010_100;
  localparam logic [5:0] LampEwGreen   = 6'b100_001;
  localparam logic [5:0] LampEwYellow  = 6'b100_010;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ns_pend_q, ns_pend_d;
  logic       ew_pend_q, ew_pend_d;
  logic [5:0] lamps_q, lamps_d;
  logic       expire;
  logic       flash_yel;

  assign expire = (timer_q == 8'd1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - 8'd1;
    if (flash) begin
      // Fault mode outranks expiry and shortening.
      if (state_q != StFlash) begin
        state_d = StFlash;
        timer_d = TFlash;
      end else if (expire) begin
        timer_d = TFlash;
      end
    end else begin
      unique case (state_q)
        StInitRed: begin
          if (expire) begin
            state_d = StNsGreen;
            timer_d = TGreen;
          end
        end
        StNsGreen: begin
          if (expire) begin
            state_d = StNsYellow;
            timer_d = TYellow;
          end else if ((ew_req || ew_pend_q) && (timer_q > TShort)) begin
            timer_d = TShort;
          end
        end
        StNsYellow: begin
          if (expire) begin
            state_d = StAllRed1;
            timer_d = TAllRed;
          end
        end
        StAllRed1: begin
          if (expire) begin
            state_d = StEwGreen;
            timer_d = TGreen;
          end
        end
        StEwGreen: begin
          if (expire) begin
            state_d = StEwYellow;
            timer_d = TYellow;
          end else if ((ns_req || ns_pend_q) && (timer_q > TShort)) begin
            timer_d = TShort;
          end
        end
        StEwYellow: begin
          if (expire) begin
            state_d = StAllRed2;
            timer_d = TAllRed;
          end
        end
        StAllRed2: begin
          if (expire) begin
            state_d = StNsGreen;
            timer_d = TGreen;
          end
        end
        StFlash: begin
          state_d = StInitRed;
          timer_d = TAllRed;
        end
        default: begin
          state_d = StInitRed;
          timer_d = TAllRed;
        end
      endcase
    end
  end

  // Entry into a direction's green clears its pending flag, even against a same-cycle request.
  always_comb begin
    ns_pend_d = ns_pend_q;
    ew_pend_d = ew_pend_q;
    if (ns_req && (state_q != StNsGreen)) ns_pend_d = 1'b1;
    if (ew_req && (state_q != StEwGreen)) ew_pend_d = 1'b1;
    if ((state_d == StNsGreen) && (state_q != StNsGreen)) ns_pend_d = 1'b0;
    if ((state_d == StEwGreen) && (state_q != StEwGreen)) ew_pend_d = 1'b0;
  end

  // Flash yellows start dark on entry and toggle together on each timer reload.
  assign flash_yel = (state_q != StFlash) ? 1'b0 : (expire ? ~lamps_q[4] : lamps_q[4]);

  always_comb begin
    lamps_d = LampRedRed;
    unique case (state_d)
      StNsGreen:  lamps_d = LampNsGreen;
      StNsYellow: lamps_d = LampNsYellow;
      StEwGreen:  lamps_d = LampEwGreen;
      StEwYellow: lamps_d = LampEwYellow;
      StFlash:    lamps_d = {1'b0, flash_yel, 1'b0, 1'b0, flash_yel, 1'b0};
      default:    lamps_d = LampRedRed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInitRed;
      timer_q   <= TAllRed;
      ns_pend_q <= 1'b0;
      ew_pend_q <= 1'b0;
      lamps_q   <= LampRedRed;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ns_pend_q <= ns_pend_d;
      ew_pend_q <= ew_pend_d;
      lamps_q   <= lamps_d;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps_q;
  assign phase = state_q;
  assign timer = timer_q;

endmodule
